// File: rtl/sar_ctrl_dms.sv
`default_nettype none
// ============================================================================
// Module   : sar_ctrl_dms
// Brief    : Successive-approximation controller closing the loop through a DAC
// Revision : 1.0 - initial release
// ============================================================================
module sar_ctrl_dms #(
  parameter int N_BITS        = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cmp_i,
  output logic              sample_o,
  output logic [N_BITS-1:0] dac_code_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [N_BITS-1:0] data_o
);

  localparam int c_cnt_max = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_idx_w   = $clog2(N_BITS);

  localparam logic [c_cnt_w-1:0] c_sample_last = c_cnt_w'(SAMPLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [c_idx_w-1:0] c_msb_idx     = c_idx_w'(N_BITS - 1);
  localparam logic [N_BITS-1:0]  c_mid_scale   = {1'b1, {(N_BITS-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_SETTLE = 3'd2,
    S_DECIDE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  logic [N_BITS-1:0]   r_result;
  logic [c_idx_w-1:0]  r_bit_idx;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [N_BITS-1:0]   w_result_next;
  logic [N_BITS-1:0]   w_next_trial;

  // Bits below k are always zero in r_result, so the next trial is just the
  // resolved result with the next lower bit raised.
  always_comb begin
    w_result_next            = r_result;
    w_result_next[r_bit_idx] = cmp_i;
    w_next_trial             = w_result_next;
    if (r_bit_idx != '0) begin
      w_next_trial[r_bit_idx - 1'b1] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_result   <= '0;
      r_bit_idx  <= '0;
      r_cnt      <= '0;
      sample_o   <= 1'b0;
      dac_code_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      data_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          dac_code_o <= '0;
          sample_o   <= 1'b0;
          if (start_i) begin
            r_state  <= S_SAMPLE;
            r_cnt    <= '0;
            sample_o <= 1'b1;
            busy_o   <= 1'b1;
          end
        end
        S_SAMPLE: begin
          if (r_cnt == c_sample_last) begin
            r_state    <= S_SETTLE;
            r_cnt      <= '0;
            sample_o   <= 1'b0;
            r_result   <= '0;
            r_bit_idx  <= c_msb_idx;
            dac_code_o <= c_mid_scale;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_cnt == c_settle_last) begin
            r_state <= S_DECIDE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DECIDE: begin
          r_result <= w_result_next;
          if (r_bit_idx == '0) begin
            // Result published on the way into DONE so it is valid with done_o.
            r_state <= S_DONE;
            data_o  <= w_result_next;
            done_o  <= 1'b1;
          end else begin
            r_state    <= S_SETTLE;
            dac_code_o <= w_next_trial;
            r_bit_idx  <= r_bit_idx - 1'b1;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          busy_o     <= 1'b0;
          dac_code_o <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sar_ctrl_dms.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_ctrl_dms
// Brief    : Directed self-checking bench for sar_ctrl_dms with a DAC/comparator model
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_ctrl_dms;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       cmp_i;
  logic       sample_o;
  logic [7:0] dac_code_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] data_o;

  real  vin;
  logic forced;
  logic cmp_f;

  int n_checks = 0;
  int n_fail   = 0;

  int         done_cnt, done_cyc0, done_cyc1;
  int         samp_first, samp_last, samp_cnt, busy_bad;
  logic [7:0] data_done;
  logic [7:0] codes     [8];
  logic [7:0] exp_codes [8];

  sar_ctrl_dms #(
    .N_BITS       (8),
    .SAMPLE_CYCLES(2),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .cmp_i     (cmp_i),
    .sample_o  (sample_o),
    .dac_code_o(dac_code_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .data_o    (data_o)
  );

  always #5 clk_i = ~clk_i;

  // DAC LSB = 1/256; the comparator wrapper resolves a tie as 1.
  assign cmp_i = forced ? cmp_f : (vin * 256.0 >= real'(dac_code_o));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start edge is cycle 0; cycle c is observed at the negedge after edge c-1.
  task automatic run_conv(input int ncyc, input bit hold, input int repulse, input logic [7:0] pat);
    done_cnt   = 0;
    done_cyc0  = -1;
    done_cyc1  = -1;
    samp_first = -1;
    samp_last  = -1;
    samp_cnt   = 0;
    busy_bad   = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk_i);
      start_i = hold || (c == repulse);
      if (c >= 5 && c <= 26 && (c - 5) % 3 == 0) cmp_f = pat[7 - (c - 5) / 3];
      else                                       cmp_f = 1'($urandom);
      if (sample_o) begin
        if (samp_first < 0) samp_first = c;
        samp_last = c;
        samp_cnt++;
      end
      if (c <= 28 && busy_o !== (c <= 27)) busy_bad++;
      if (done_o) begin
        if (done_cnt == 0) begin
          done_cyc0 = c;
          data_done = data_o;
        end else begin
          done_cyc1 = c;
        end
        done_cnt++;
      end
      if (c >= 3 && c <= 24 && (c - 3) % 3 == 0) codes[(c - 3) / 3] = dac_code_o;
    end
    start_i = 1'b0;
  endtask

  initial begin
    int dn;
    rst_i   = 1'b1;
    start_i = 1'b0;
    vin     = 0.0;
    forced  = 1'b0;
    cmp_f   = 1'b0;
    exp_codes[0] = 8'd128; exp_codes[1] = 8'd192; exp_codes[2] = 8'd160; exp_codes[3] = 8'd144;
    exp_codes[4] = 8'd136; exp_codes[5] = 8'd132; exp_codes[6] = 8'd130; exp_codes[7] = 8'd129;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_sample", sample_o, 0);
    check_val("rst_dac", dac_code_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_data", data_o, 0);
    rst_i = 1'b0;

    // Just above mid-scale: full trial-code trace and latency
    vin = 0.5005;
    run_conv(30, 1'b0, 0, 8'h00);
    check_val("mid_data", data_done, 128);
    check_val("mid_done_cnt", done_cnt, 1);
    check_val("mid_done_cyc", done_cyc0, 27);
    check_val("mid_samp_first", samp_first, 1);
    check_val("mid_samp_last", samp_last, 2);
    check_val("mid_samp_cnt", samp_cnt, 2);
    check_val("mid_busy", busy_bad, 0);
    for (int i = 0; i < 8; i++) check_val($sformatf("mid_code%0d", i), codes[i], exp_codes[i]);
    check_val("mid_idle_dac", dac_code_o, 0);
    check_val("mid_hold_data", data_o, 128);

    vin = 0.999;
    run_conv(30, 1'b0, 0, 8'h00);
    check_val("full_data", data_done, 255);
    check_val("full_done_cnt", done_cnt, 1);

    vin = 0.0;
    run_conv(30, 1'b0, 0, 8'h00);
    check_val("zero_data", data_done, 0);
    check_val("zero_done_cnt", done_cnt, 1);

    // Forced decisions, noise on cmp_i outside DECIDE
    forced = 1'b1;
    run_conv(30, 1'b0, 0, 8'hAA);
    check_val("aa_data", data_done, 170);
    check_val("aa_busy", busy_bad, 0);
    check_val("aa_done_cyc", done_cyc0, 27);
    forced = 1'b0;

    vin = 0.75;
    run_conv(40, 1'b0, 10, 8'h00);
    check_val("repulse_done_cnt", done_cnt, 1);
    check_val("repulse_done_cyc", done_cyc0, 27);
    check_val("repulse_data", data_done, 192);

    run_conv(60, 1'b1, 0, 8'h00);
    check_val("b2b_done_cnt", done_cnt, 2);
    check_val("b2b_done_cyc0", done_cyc0, 27);
    check_val("b2b_done_cyc1", done_cyc1, 55);
    repeat (35) @(negedge clk_i);
    check_val("b2b_idle_busy", busy_o, 0);

    // Asynchronous reset in the middle of a conversion
    vin = 0.5005;
    dn  = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk_i);
      if (done_o) dn++;
    end
    check_val("pre_rst_busy", busy_o, 1);
    #1 rst_i = 1'b1;
    #1;
    check_val("arst_sample", sample_o, 0);
    check_val("arst_dac", dac_code_o, 0);
    check_val("arst_busy", busy_o, 0);
    check_val("arst_done", done_o, 0);
    check_val("arst_data", data_o, 0);
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) dn++;
    end
    rst_i = 1'b0;
    repeat (15) begin
      @(negedge clk_i);
      if (done_o) dn++;
    end
    check_val("arst_no_done", dn, 0);

    vin = 0.25;
    run_conv(30, 1'b0, 0, 8'h00);
    check_val("post_rst_data", data_done, 64);
    check_val("post_rst_done_cyc", done_cyc0, 27);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
